// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg
//   Shared types and constants for the ring-oscillator measurement sequencer.
//   state_e  : sequencer states IDLE / SETTLE / MEASURE / DONE
//   TAP_W    : width of the ring stage tap select
//   GATE_SEL_W : width of the gate window select
package ro_meas_pkg;

    localparam int TAP_W      = 3;
    localparam int GATE_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } state_e;

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// ro_meas_ctrl_if
//   Host-side control/result bundle of ro_meas_ctrl.
//   Requests (master -> slave): ena, start, tap_sel, gate_sel, cont
//   Results  (slave -> master): busy, done, valid, overflow, count[CNT_W]
//   cont only has an effect when the sequencer is built with RO_CONT_MEAS_EN.
interface ro_meas_ctrl_if #(
    parameter int CNT_W = 16
);
    import ro_meas_pkg::*;

    logic                  ena;
    logic                  start;
    logic [TAP_W-1:0]      tap_sel;
    logic [GATE_SEL_W-1:0] gate_sel;
    logic                  cont;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic                  overflow;
    logic [CNT_W-1:0]      count;

    modport master (
        output ena, start, tap_sel, gate_sel, cont,
        input  busy, done, valid, overflow, count
    );

    modport slave (
        input  ena, start, tap_sel, gate_sel, cont,
        output busy, done, valid, overflow, count
    );

endinterface

// File: rtl/ro_sync_edge.sv
// ro_sync_edge
//   Brings the asynchronous divided ring output into the clk domain with a
//   2-FF synchroniser and produces a registered one-cycle pulse per rising
//   edge. Total path from ro_sig to rise is three clk cycles.
//   Ports: clk, rst_n (async active-low), async_in (ro_sig), rise (pulse out)
module ro_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl
//   Measurement sequencer for the on-chip ring oscillator: on a start edge it
//   enables the ring on the selected tap, waits SETTLE_CYC cycles, counts
//   synchronised ro_sig rising edges for 2^(GATE_LOG2_MIN+gate_sel) cycles,
//   publishes the (saturating) count and returns to IDLE.
//   Ports: clk, rst_n (async assert, synchronously released internally),
//          bus (ro_meas_ctrl_if.slave: ena/start/tap_sel/gate_sel/cont in,
//          busy/done/valid/overflow/count out), ro_sig (async ring output),
//          ro_en / ro_tap (to the analog ring macro).
//   Optional feature macro: RO_CONT_MEAS_EN -- back-to-back measurements
//   while cont=1; without it cont is ignored.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYC    = 16,
    parameter int GATE_LOG2_MIN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ro_meas_ctrl_if.slave     bus,
    input  logic              ro_sig,
    output logic              ro_en,
    output logic [TAP_W-1:0]  ro_tap
);

    localparam int GATE_LOG2_MAX = GATE_LOG2_MIN + (2 ** GATE_SEL_W) - 1;
    localparam int SETTLE_BITS   = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W         = (GATE_LOG2_MAX + 1 > SETTLE_BITS) ? GATE_LOG2_MAX + 1 : SETTLE_BITS;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // Timer counts down to zero; the load value is window length minus one.
    function automatic logic [TMR_W-1:0] gate_last(input logic [GATE_SEL_W-1:0] sel);
        return (TMR_W'(1) << (GATE_LOG2_MIN + int'(sel))) - TMR_W'(1);
    endfunction

    logic rst_meta_q, rst_meta_d;
    logic rst_sync_q, rst_sync_d;

    state_e                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      counter_q, counter_d;
    logic                  sat_q, sat_d;
    logic                  start_prev_q, start_prev_d;
    logic [TAP_W-1:0]      tap_q, tap_d;
    logic [GATE_SEL_W-1:0] gate_q, gate_d;
    logic                  ro_en_q, ro_en_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    logic ro_rise;
    logic start_rise;

    // Reset asserts immediately, releases two clk edges after rst_n rises.
    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    ro_sync_edge u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_sync_q),
        .async_in (ro_sig),
        .rise     (ro_rise)
    );

    assign start_rise = bus.start & ~start_prev_q;

    // Result registers are loaded on entry to DONE so that count/valid/overflow
    // are already current while done is high; ro_en drops when DONE is left.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        counter_d    = counter_q;
        sat_d        = sat_q;
        start_prev_d = bus.start;
        tap_d        = tap_q;
        gate_d       = gate_q;
        ro_en_d      = ro_en_q;
        count_d      = count_q;
        valid_d      = valid_q;
        overflow_d   = overflow_q;

        if (!bus.ena) begin
            state_d = IDLE;
            ro_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_d    = SETTLE;
                        tap_d      = bus.tap_sel;
                        gate_d     = bus.gate_sel;
                        ro_en_d    = 1'b1;
                        counter_d  = '0;
                        sat_d      = 1'b0;
                        valid_d    = 1'b0;
                        overflow_d = 1'b0;
                        timer_d    = SETTLE_LAST;
                    end
                end
                SETTLE: begin
                    if (timer_q == '0) begin
                        state_d = MEASURE;
                        timer_d = gate_last(gate_q);
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (ro_rise) begin
                        if (counter_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            counter_d = counter_q + CNT_W'(1);
                        end
                    end
                    if (timer_q == '0) begin
                        state_d    = DONE;
                        count_d    = counter_d;
                        valid_d    = 1'b1;
                        overflow_d = sat_d;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                DONE: begin
`ifdef RO_CONT_MEAS_EN
                    if (bus.cont) begin
                        state_d   = SETTLE;
                        tap_d     = bus.tap_sel;
                        gate_d    = bus.gate_sel;
                        counter_d = '0;
                        sat_d     = 1'b0;
                        timer_d   = SETTLE_LAST;
                    end else begin
                        state_d = IDLE;
                        ro_en_d = 1'b0;
                    end
`else
                    state_d = IDLE;
                    ro_en_d = 1'b0;
`endif
                end
                default: begin
                    state_d = IDLE;
                    ro_en_d = 1'b0;
                end
            endcase
        end
    end

`ifndef RO_CONT_MEAS_EN
    logic unused_cont;
    assign unused_cont = bus.cont;
`endif

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            counter_q    <= '0;
            sat_q        <= 1'b0;
            start_prev_q <= 1'b0;
            tap_q        <= '0;
            gate_q       <= '0;
            ro_en_q      <= 1'b0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            counter_q    <= counter_d;
            sat_q        <= sat_d;
            start_prev_q <= start_prev_d;
            tap_q        <= tap_d;
            gate_q       <= gate_d;
            ro_en_q      <= ro_en_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ro_en        = ro_en_q;
    assign ro_tap       = tap_q;
    assign bus.busy     = (state_q == SETTLE) || (state_q == MEASURE);
    assign bus.done     = (state_q == DONE);
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb_ro_meas_ctrl
//   Self-checking bench for ro_meas_ctrl (CNT_W=16 main instance plus a
//   CNT_W=8 instance for saturation). Covers reset values, a table of
//   measurements, start re-pulses while busy, ena abort, cont handling
//   (RO_CONT_MEAS_EN aware) and reset asserted mid-measurement.
module tb_ro_meas_ctrl;
    import ro_meas_pkg::*;

    localparam int SETTLE = 16;
    localparam int GMIN   = 8;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             ro_sig = 1'b0;
    logic             ro_en, ro_en8;
    logic [TAP_W-1:0] ro_tap, ro_tap8;
    int               ro_period = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    ro_meas_ctrl_if #(.CNT_W(16)) bus ();
    ro_meas_ctrl_if #(.CNT_W(8))  bus8 ();

    ro_meas_ctrl #(.CNT_W(16), .SETTLE_CYC(SETTLE), .GATE_LOG2_MIN(GMIN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .ro_sig (ro_sig),
        .ro_en  (ro_en),
        .ro_tap (ro_tap)
    );

    ro_meas_ctrl #(.CNT_W(8), .SETTLE_CYC(SETTLE), .GATE_LOG2_MIN(GMIN)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus8.slave),
        .ro_sig (ro_sig),
        .ro_en  (ro_en8),
        .ro_tap (ro_tap8)
    );

    always #5 clk = ~clk;

    // Divided ring output: square wave of ro_period clk cycles, 0 when off.
    always begin
        if (ro_period < 2) begin
            ro_sig = 1'b0;
            @(negedge clk);
        end else begin
            ro_sig = 1'b1;
            repeat (ro_period / 2) @(negedge clk);
            ro_sig = 1'b0;
            repeat (ro_period - ro_period / 2) @(negedge clk);
        end
    end

    typedef struct {
        logic [2:0] tap;
        logic [1:0] gate;
        int         period;
        int         exp_cnt;
        int         tol;
        logic       exp_ovf;
        int         exp_busy;
    } vec_t;

    typedef struct {
        int         busy;
        int         lo;
        int         hi;
        logic       ovf;
        logic [2:0] tap;
    } exp_t;

    vec_t vecs [5];
    exp_t sb_q [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulseStart(input logic [2:0] tap, input logic [1:0] gate);
        @(negedge clk);
        bus.tap_sel  = tap;
        bus.gate_sel = gate;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("start_ro_en", ro_en, 1);
        checkOutput("start_busy", bus.busy, 1);
        checkOutput("start_ro_tap", ro_tap, tap);
        checkOutput("start_valid", bus.valid, 0);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        ro_period = v.period;
        repeat (24) @(negedge clk);
        e.busy = v.exp_busy;
        e.lo   = v.exp_cnt - v.tol;
        e.hi   = v.exp_cnt + v.tol;
        e.ovf  = v.exp_ovf;
        e.tap  = v.tap;
        sb_q.push_back(e);
        pulseStart(v.tap, v.gate);
    endtask

    task automatic scoreResult();
        exp_t e;
        int   lat;
        int   busy_cyc;
        bit   seen;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL sb_empty: got 0 entries, expected 1");
            return;
        end
        e        = sb_q.pop_front();
        lat      = 0;
        busy_cyc = 1;
        seen     = 1'b0;
        while (!seen && lat < e.busy + 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cyc++;
        end
        checkOutput("done_seen", 32'(seen), 1);
        checkOutput("latency", lat, e.busy);
        checkOutput("busy_cycles", busy_cyc, e.busy);
        checkRange("count", int'(bus.count), e.lo, e.hi);
        checkOutput("overflow", bus.overflow, e.ovf);
        checkOutput("valid_in_done", bus.valid, 1);
        checkOutput("ro_tap_in_done", ro_tap, e.tap);
        checkOutput("ro_en_in_done", ro_en, 1);
        checkOutput("busy_in_done", bus.busy, 0);
        @(posedge clk);
        #1;
        checkOutput("done_after", bus.done, 0);
        checkOutput("valid_after", bus.valid, 1);
        checkOutput("ro_en_after", ro_en, 0);
        checkOutput("busy_after", bus.busy, 0);
    endtask

    task automatic countDones(input int cycles, output int dones, output int busys);
        dones = 0;
        busys = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
            if (bus.busy) busys++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dones, busys, w, gap, low;

        vecs[0] = '{tap: 3'd5, gate: 2'd0, period: 8, exp_cnt: 32,  tol: 1, exp_ovf: 1'b0, exp_busy: 272};
        vecs[1] = '{tap: 3'd2, gate: 2'd1, period: 4, exp_cnt: 128, tol: 1, exp_ovf: 1'b0, exp_busy: 528};
        vecs[2] = '{tap: 3'd7, gate: 2'd3, period: 8, exp_cnt: 256, tol: 1, exp_ovf: 1'b0, exp_busy: 2064};
        vecs[3] = '{tap: 3'd0, gate: 2'd2, period: 0, exp_cnt: 0,   tol: 0, exp_ovf: 1'b0, exp_busy: 1040};
        vecs[4] = '{tap: 3'd3, gate: 2'd0, period: 6, exp_cnt: 42,  tol: 1, exp_ovf: 1'b0, exp_busy: 272};

        bus.ena = 1'b1;   bus.start = 1'b0;  bus.tap_sel = '0;  bus.gate_sel = '0;  bus.cont = 1'b0;
        bus8.ena = 1'b1;  bus8.start = 1'b0; bus8.tap_sel = '0; bus8.gate_sel = '0; bus8.cont = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ro_en", ro_en, 0);
        checkOutput("rst_ro_tap", ro_tap, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_valid", bus.valid, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        checkOutput("rst_count", bus.count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table of single measurements
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            scoreResult();
        end

        // Start re-pulsed while busy: ignored, tap unchanged, one done only
        applyStimulus(vecs[0]);
        fork
            scoreResult();
            begin
                repeat (3) begin
                    repeat (40) @(negedge clk);
                    bus.start   = 1'b1;
                    bus.tap_sel = 3'd1;
                    repeat (2) @(negedge clk);
                    bus.start   = 1'b0;
                end
            end
        join
        countDones(300, dones, busys);
        checkOutput("repulse_extra_done", dones, 0);
        checkOutput("repulse_extra_busy", busys, 0);

        // ena dropped mid-SETTLE
        pulseStart(3'd4, 2'd1);
        repeat (5) @(negedge clk);
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_ro_en", ro_en, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_valid", bus.valid, 0);
        checkOutput("abort_done", bus.done, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ena_low_start_busy", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ena   = 1'b1;
        countDones(600, dones, busys);
        checkOutput("abort_no_done", dones, 0);
        checkOutput("abort_no_busy", busys, 0);

`ifdef RO_CONT_MEAS_EN
        // Continuous mode: done every 273 cycles, ro_en never drops
        ro_period = 8;
        repeat (24) @(negedge clk);
        bus.cont = 1'b1;
        pulseStart(3'd5, 2'd0);
        w = 0;
        while (!bus.done && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput("cont_first_done", bus.done, 1);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            low = 0;
            do begin
                @(posedge clk);
                #1;
                gap++;
                if (!ro_en) low++;
            end while (!bus.done && gap < 400);
            checkOutput("cont_period", gap, 273);
            checkOutput("cont_ro_en_low", low, 0);
            checkRange("cont_count", int'(bus.count), 31, 33);
            checkOutput("cont_valid", bus.valid, 1);
        end
        @(posedge clk);
        #1;
        gap = 1;
        @(negedge clk);
        bus.cont = 1'b0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!bus.done && gap < 400);
        checkOutput("cont_last_period", gap, 273);
        @(posedge clk);
        #1;
        checkOutput("cont_stop_ro_en", ro_en, 0);
        checkOutput("cont_stop_busy", bus.busy, 0);
        countDones(300, dones, busys);
        checkOutput("cont_stop_no_done", dones, 0);
`else
        // cont ignored: measurement ends after one result
        bus.cont = 1'b1;
        applyStimulus(vecs[0]);
        scoreResult();
        countDones(300, dones, busys);
        checkOutput("cont_ignored_no_done", dones, 0);
        checkOutput("cont_ignored_no_busy", busys, 0);
        bus.cont = 1'b0;
`endif

        // CNT_W=8 saturation
        ro_period = 4;
        repeat (24) @(negedge clk);
        bus8.tap_sel  = 3'd1;
        bus8.gate_sel = 2'd3;
        bus8.start    = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        w = 0;
        while (!bus8.done && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput("sat_done_seen", bus8.done, 1);
        checkOutput("sat_count", bus8.count, 255);
        checkOutput("sat_overflow", bus8.overflow, 1);
        checkOutput("sat_valid", bus8.valid, 1);
        checkOutput("sat_ro_tap", ro_tap8, 1);

        // Reset asserted mid-MEASURE
        ro_period = 8;
        repeat (24) @(negedge clk);
        pulseStart(3'd6, 2'd0);
        repeat (SETTLE + 40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ro_en", ro_en, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        checkOutput("midrst_count", bus.count, 0);
        checkOutput("midrst_ro_tap", ro_tap, 0);
        checkOutput("midrst_valid8", bus8.valid, 0);
        checkOutput("midrst_count8", bus8.count, 0);
        checkOutput("midrst_overflow8", bus8.overflow, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        countDones(400, dones, busys);
        checkOutput("postrst_no_done", dones, 0);
        checkOutput("postrst_no_busy", busys, 0);
        checkOutput("postrst_ro_en", ro_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
